fb_write_sched: RTL and testbench

FB_WRITE_SCHED -- requirements
Module: fb_write_sched

---
 rtl/fb_write_sched.sv | 163 ++++++++++++++++
 tb/tb_fb_write_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: queues single-cell writes and runs full-screen clear sweeps.
// Optional macro FB_BLANK_GATE_EN: write slots only while blank=1; otherwise every cycle is a slot.
module fb_write_sched #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_we,
  input  logic [9:0] cmd_waddr,
  input  logic [2:0] cmd_wdata,
  input  logic       clr_req,
  input  logic [2:0] clr_color,
  input  logic       blank,
  output logic       fb_we,
  output logic [9:0] fb_waddr,
  output logic [2:0] fb_wdata,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  color;
  } entry_t;

  state_e              state_q, state_d;
  entry_t              mem_q [FIFO_DEPTH];
  logic [AW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]       count_q, count_d, count_base;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [COL_W-1:0]    color_q, color_d;
  logic                fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]   fb_waddr_q, fb_waddr_d;
  logic [COL_W-1:0]    fb_wdata_q, fb_wdata_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                slot, pop, push_ok, clear_last;
  entry_t              rd_entry;

`ifdef FB_BLANK_GATE_EN
  assign slot = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign slot = 1'b1;
`endif

  assign rd_entry = mem_q[rptr_q];

  // Next-state, queue bookkeeping and write-port selection; a clr_req cycle issues no write.
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    sweep_d    = sweep_q;
    color_d    = color_q;
    fb_we_d    = 1'b0;
    fb_waddr_d = fb_waddr_q;
    fb_wdata_d = fb_wdata_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push_ok    = 1'b0;
    clear_last = 1'b0;

    case (state_q)
      DRAIN: begin
        if (!clr_req && slot && count_q != '0) begin
          pop        = 1'b1;
          fb_we_d    = 1'b1;
          fb_waddr_d = rd_entry.addr;
          fb_wdata_d = rd_entry.color;
          rptr_d     = rptr_q + AW'(1);
        end
      end
      CLEAR: begin
        if (!clr_req && slot) begin
          fb_we_d    = 1'b1;
          fb_waddr_d = sweep_q;
          fb_wdata_d = color_q;
          sweep_d    = sweep_q + ADDR_W'(1);
          if (sweep_q == LAST_ADDR) begin
            clear_last = 1'b1;
            busy_d     = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // A clear flushes first, so a coincident push lands in the emptied queue.
    if (clr_req) begin
      rptr_d     = wptr_q;
      sweep_d    = '0;
      color_d    = clr_color;
      busy_d     = 1'b1;
      count_base = '0;
    end else begin
      count_base = count_q - CW'(pop);
    end

    if (cmd_we) begin
      if (count_base < CW'(FIFO_DEPTH)) push_ok = 1'b1;
      else                              overflow_d = 1'b1;
    end
    wptr_d  = wptr_q + AW'(push_ok);
    count_d = count_base + CW'(push_ok);

    if (clr_req)                              state_d = CLEAR;
    else if (state_q == CLEAR && !clear_last) state_d = CLEAR;
    else if (count_d != '0)                   state_d = DRAIN;
    else                                      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      sweep_q    <= '0;
      color_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      sweep_q    <= sweep_d;
      color_q    <= color_d;
      fb_we_q    <= fb_we_d;
      fb_waddr_q <= fb_waddr_d;
      fb_wdata_q <= fb_wdata_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Queue storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wptr_q] <= '{addr: cmd_waddr, color: cmd_wdata};
  end

  assign fb_we     = fb_we_q;
  assign fb_waddr  = fb_waddr_q;
  assign fb_wdata  = fb_wdata_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_fb_write_sched;
  localparam int DEPTH = 8;
`ifdef FB_BLANK_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_we = 1'b0;
  logic [9:0] cmd_waddr = '0;
  logic [2:0] cmd_wdata = '0;
  logic       clr_req = 1'b0;
  logic [2:0] clr_color = '0;
  logic       blank = 1'b0;
  logic       fb_we;
  logic [9:0] fb_waddr;
  logic [2:0] fb_wdata;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  fb_write_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_we(cmd_we), .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
    .clr_req(clr_req), .clr_color(clr_color), .blank(blank),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;
  int n_wr      = 0;

  // Reference model: pending writes as a queue, clear as a counter walking the screen.
  logic [12:0] mq[$];
  bit          m_clearing = 1'b0;
  int          m_sweep = 0;
  logic [2:0]  m_ccol = '0;
  logic        m_we = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [2:0]  m_data = '0;
  logic        m_busy = 1'b0;
  logic        m_ovf = 1'b0;

  task automatic model_edge(input logic rst, input logic we, input logic [9:0] wa,
                            input logic [2:0] wd, input logic clr, input logic [2:0] cc,
                            input logic bl);
    logic [12:0] e;
    bit s;
    if (!rst) begin
      mq.delete();
      m_clearing = 1'b0; m_sweep = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
      m_busy = 1'b0; m_ovf = 1'b0;
      return;
    end
    s = GATE ? bl : 1'b1;
    m_we = 1'b0;
    if (clr) begin
      mq.delete();
      m_clearing = 1'b1; m_sweep = 0; m_ccol = cc; m_busy = 1'b1;
    end else if (m_clearing) begin
      if (s) begin
        m_we = 1'b1; m_addr = 10'(m_sweep); m_data = m_ccol;
        if (m_sweep == 1023) begin m_clearing = 1'b0; m_busy = 1'b0; end
        else m_sweep++;
      end
    end else if (mq.size() > 0 && s) begin
      e = mq.pop_front();
      m_we = 1'b1; m_addr = e[12:3]; m_data = e[2:0];
    end
    if (we) begin
      if (mq.size() < DEPTH) mq.push_back({wa, wd});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("fb_we",     32'(fb_we),     32'(m_we));
    check("fb_waddr",  32'(fb_waddr),  32'(m_addr));
    check("fb_wdata",  32'(fb_wdata),  32'(m_data));
    check("busy",      32'(busy),      32'(m_busy));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
  endtask

  task automatic step(input logic rst, input logic we, input logic [9:0] wa, input logic [2:0] wd,
                      input logic clr, input logic [2:0] cc, input logic bl);
    @(negedge clk);
    reset = rst; cmd_we = we; cmd_waddr = wa; cmd_wdata = wd;
    clr_req = clr; clr_color = cc; blank = bl;
    @(posedge clk);
    model_edge(rst, we, wa, wd, clr, cc, bl);
    #1;
    if (fb_we) n_wr++;
    check_all();
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, bl);
  endtask

  initial begin
    // Reset with stray requests that must be ignored.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'(i), 10'h155, 3'd6, 1'(i), 3'd7, 1'b1);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_waddr", 32'(fb_waddr), 32'd0);

    // Single write: visible two edges after the request, for one cycle.
    step(1'b1, 1'b1, 10'h021, 3'd5, 1'b0, '0, 1'b1);
    check("single_lat1", 32'(fb_we), 32'd0);
    idle(1, 1'b1);
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_waddr), 32'h021);
    check("single_data", 32'(fb_wdata), 32'd5);
    idle(1, 1'b1);
    check("single_once", 32'(fb_we), 32'd0);

    // Full clear with colour 3.
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd3, 1'b1);
    check("clr_busy", 32'(busy), 32'd1);
    n_wr = 0;
    idle(1030, 1'b1);
    check("clr_count", 32'(n_wr), 32'd1024);
    check("clr_done", 32'(busy), 32'd0);

    // Flush: queued writes vanish, the coincident write survives.
    step(1'b1, 1'b1, 10'h011, 3'd1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 10'h012, 3'd2, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 10'h013, 3'd3, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 10'h3ab, 3'd7, 1'b1, 3'd1, 1'b0);
    idle(1030, 1'b1);
    check("flush_last_addr", 32'(fb_waddr), 32'h3ab);
    check("flush_last_data", 32'(fb_wdata), 32'd7);

    // Overflow: nine requests into an eight-deep queue with no write slots.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 10'(i + 40), 3'(i), 1'b0, '0, 1'b0);
`ifdef FB_BLANK_GATE_EN
      if (i == 7) check("ovf_full", 32'(fifo_full), 32'd1);
`endif
    end
`ifdef FB_BLANK_GATE_EN
    check("ovf_flag", 32'(overflow), 32'd1);
`endif
    idle(12, 1'b1);

    // Restart a clear part-way through with a new colour.
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd2, 1'b1);
    idle(100, 1'b1);
    check("restart_pre", 32'(fb_waddr), 32'd99);
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd6, 1'b1);
    check("restart_busy", 32'(busy), 32'd1);
    idle(1, 1'b1);
    check("restart_addr", 32'(fb_waddr), 32'd0);
    check("restart_data", 32'(fb_wdata), 32'd6);
    idle(1030, 1'b1);

    // Reset in the middle of a sweep.
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 1'b1);
    idle(500, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("midrst_we", 32'(fb_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n_wr = 0;
    idle(5, 1'b1);
    check("midrst_quiet", 32'(n_wr), 32'd0);

    // Random traffic with bursts of closed write slots.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 999) != 0), 1'($urandom_range(0, 1)), 10'($urandom),
           3'($urandom), 1'($urandom_range(0, 299) == 0), 3'($urandom),
           ((c / 40) % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
